// File: rtl/q_table_updater_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q_table_pkg
// Description : Shared types, default sizes and the field-extract helper for
//               the Q-table update datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package q_table_pkg;

  // Update sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_NEXT = 3'd1,
    RD_CUR  = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } q_state_e;

  localparam int DEF_N_ACT  = 4;
  localparam int DEF_Q_W    = 4;
  localparam int DEF_R_W    = 4;
  localparam int DEF_ADDR_W = 6;

  // Widest word / field the helper accepts; callers zero-extend into it
  localparam int MAX_WORD_W  = 256;
  localparam int MAX_FIELD_W = 32;

  // Return field idx (q_w bits wide) of a packed word, zero-extended
  function automatic logic [MAX_FIELD_W-1:0] get_field(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           idx,
    input int unsigned           q_w
  );
    logic [MAX_FIELD_W-1:0] f;
    f = '0;
    for (int unsigned b = 0; b < MAX_FIELD_W; b++) begin
      if (b < q_w) f[b] = word[idx*q_w + b];
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_table_updater_if.sv
`default_nettype none
// ============================================================================
// Module      : q_table_updater_if
// Description : Transition request / response handshake and action-RAM port
//               bundle for the Q-table updater.
// Revision    : 1.0 - initial release
// ============================================================================
interface q_table_updater_if
  import q_table_pkg::*;
#(
  parameter int N_ACT  = DEF_N_ACT,
  parameter int Q_W    = DEF_Q_W,
  parameter int R_W    = DEF_R_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  localparam int A_W = (N_ACT > 1) ? $clog2(N_ACT) : 1;

  // Request channel
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_state;
  logic [A_W-1:0]          req_action;
  logic signed [R_W-1:0]   req_reward;
  logic [ADDR_W-1:0]       req_next_state;
  logic                    req_terminal;

  // Response
  logic                    done;
  logic [A_W-1:0]          best_action;

  // Action RAM
  logic                    ram_en;
  logic [ADDR_W-1:0]       ram_rd_addr;
  logic [N_ACT*Q_W-1:0]    ram_rd_data;
  logic [ADDR_W-1:0]       ram_wr_addr;
  logic [N_ACT*Q_W-1:0]    ram_wr_data;
  logic                    ram_write_en;

  // The updater side
  modport slave (
    input  req_valid, req_state, req_action, req_reward, req_next_state,
           req_terminal, ram_rd_data,
    output req_ready, done, best_action, ram_en, ram_rd_addr, ram_wr_addr,
           ram_wr_data, ram_write_en
  );

  // The agent FSM / RAM side
  modport master (
    output req_valid, req_state, req_action, req_reward, req_next_state,
           req_terminal, ram_rd_data,
    input  req_ready, done, best_action, ram_en, ram_rd_addr, ram_wr_addr,
           ram_wr_data, ram_write_en
  );
endinterface
`default_nettype wire

// File: rtl/q_table_updater_argmax.sv
`default_nettype none
// ============================================================================
// Module      : q_argmax
// Description : Combinational max / argmax over N_ACT packed unsigned fields.
//               Ties resolve to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module q_argmax #(
  parameter int N_ACT = 4,
  parameter int Q_W   = 4,
  parameter int A_W   = (N_ACT > 1) ? $clog2(N_ACT) : 1
) (
  input  wire logic [N_ACT*Q_W-1:0] i_word,
  output logic      [Q_W-1:0]       o_max,
  output logic      [A_W-1:0]       o_idx
);

  // Linear scan; strict compare keeps the first (lowest) index on ties
  always_comb begin
    o_max = i_word[Q_W-1:0];
    o_idx = '0;
    for (int a = 1; a < N_ACT; a++) begin
      if (i_word[a*Q_W +: Q_W] > o_max) begin
        o_max = i_word[a*Q_W +: Q_W];
        o_idx = A_W'(a);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/q_table_updater.sv
`default_nettype none
// ============================================================================
// Module      : q_table_updater
// Description : Read-modify-write Q-learning update of one action field of
//               the action RAM, returning the greedy next action.
//               Optional statistics counters under Q_UPDATE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module q_table_updater
  import q_table_pkg::*;
#(
  parameter int N_ACT   = DEF_N_ACT,
  parameter int Q_W     = DEF_Q_W,
  parameter int R_W     = DEF_R_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int A_SHIFT = 1,
  parameter int G_SHIFT = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  q_table_updater_if.slave   bus
`ifdef Q_UPDATE_STATS_EN
  ,
  output logic [15:0]        upd_count,
  output logic [15:0]        sat_count
`endif
);

  localparam int A_W    = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int W      = Q_W + R_W + 2;
  localparam int WORD_W = N_ACT * Q_W;

  localparam logic [2:0] c_IDLE    = IDLE;
  localparam logic [2:0] c_RD_NEXT = RD_NEXT;
  localparam logic [2:0] c_RD_CUR  = RD_CUR;
  localparam logic [2:0] c_WRITE   = WRITE;
  localparam logic [2:0] c_DONE    = DONE;

  logic [2:0]            r_state;
  logic [ADDR_W-1:0]     r_s;
  logic [ADDR_W-1:0]     r_sn;
  logic [A_W-1:0]        r_action;
  logic signed [R_W-1:0] r_reward;
  logic                  r_term;
  logic [Q_W-1:0]        r_maxq;
  logic [A_W-1:0]        r_arg;
  logic [WORD_W-1:0]     r_word;

  logic [Q_W-1:0]        w_max;
  logic [A_W-1:0]        w_idx;
  logic [Q_W-1:0]        w_q;
  logic signed [W-1:0]   w_r_s, w_maxq_s, w_q_s, w_target, w_delta, w_newq;
  logic                  w_sat_lo, w_sat_hi;
  logic [Q_W-1:0]        w_newq_f;
  logic [WORD_W-1:0]     w_new_word;

  q_argmax #(
    .N_ACT (N_ACT),
    .Q_W   (Q_W),
    .A_W   (A_W)
  ) u_argmax (
    .i_word (bus.ram_rd_data),
    .o_max  (w_max),
    .o_idx  (w_idx)
  );

  // Shift-based update of the selected field, saturated to the field range
  always_comb begin
    w_q        = Q_W'(get_field(MAX_WORD_W'(bus.ram_rd_data), 32'(r_action), Q_W));
    w_r_s      = W'(r_reward);
    w_maxq_s   = signed'(W'(r_maxq));
    w_q_s      = signed'(W'(w_q));
    w_target   = w_r_s + w_maxq_s - (w_maxq_s >>> G_SHIFT);
    w_delta    = w_target - w_q_s;
    w_newq     = w_q_s + (w_delta >>> A_SHIFT);
    w_sat_lo   = w_newq[W-1];
    w_sat_hi   = !w_newq[W-1] && (|w_newq[W-2:Q_W]);
    w_newq_f   = w_sat_lo ? '0 : (w_sat_hi ? '1 : w_newq[Q_W-1:0]);
    w_new_word = bus.ram_rd_data;
    w_new_word[32'(r_action)*Q_W +: Q_W] = w_newq_f;
  end

  // Sequencer and datapath registers; reset aborts any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_s      <= '0;
      r_sn     <= '0;
      r_action <= '0;
      r_reward <= '0;
      r_term   <= 1'b0;
      r_maxq   <= '0;
      r_arg    <= '0;
      r_word   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.req_valid) begin
            r_s      <= bus.req_state;
            r_sn     <= bus.req_next_state;
            r_action <= bus.req_action;
            r_reward <= bus.req_reward;
            r_term   <= bus.req_terminal;
            r_state  <= c_RD_NEXT;
          end
        end
        c_RD_NEXT: begin
          // Terminal next state contributes no future value, but the
          // greedy action is still taken from the stored word
          r_maxq  <= r_term ? '0 : w_max;
          r_arg   <= w_idx;
          r_state <= c_RD_CUR;
        end
        c_RD_CUR: begin
          r_word  <= w_new_word;
          r_state <= c_WRITE;
        end
        c_WRITE: r_state <= c_DONE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == c_IDLE);
  assign bus.ram_en       = (r_state != c_IDLE);
  assign bus.ram_write_en = (r_state == c_WRITE);
  assign bus.done         = (r_state == c_DONE);
  assign bus.best_action  = (r_state == c_DONE) ? r_arg : '0;
  assign bus.ram_rd_addr  = (r_state == c_RD_NEXT) ? r_sn :
                            (r_state == c_RD_CUR)  ? r_s  : '0;
  assign bus.ram_wr_addr  = (r_state == c_WRITE) ? r_s    : '0;
  assign bus.ram_wr_data  = (r_state == c_WRITE) ? r_word : '0;

`ifdef Q_UPDATE_STATS_EN
  logic [15:0] r_upd_count;
  logic [15:0] r_sat_count;

  // Wrapping counters of committed updates and clamp events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_count <= '0;
      r_sat_count <= '0;
    end else begin
      if (r_state == c_DONE) r_upd_count <= r_upd_count + 16'd1;
      if ((r_state == c_RD_CUR) && (w_sat_lo || w_sat_hi))
        r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign upd_count = r_upd_count;
  assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_q_table_updater.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_table_updater
// Description : Self-checking bench for q_table_updater with a behavioural
//               action RAM and an expected-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_table_updater;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q_table_updater_if bus ();

`ifdef Q_UPDATE_STATS_EN
  logic [15:0] upd_count, sat_count;
`endif

  q_table_updater dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef Q_UPDATE_STATS_EN
    ,
    .upd_count (upd_count),
    .sat_count (sat_count)
`endif
  );

  // Behavioural action RAM: combinational read, clocked write
  logic [15:0] ram   [64];
  logic [15:0] m_ram [64];
  assign bus.ram_rd_data = ram[bus.ram_rd_addr];
  always @(posedge clk) if (bus.ram_write_en) ram[bus.ram_wr_addr] <= bus.ram_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] word;
    logic [1:0]  best;
  } exp_t;

  exp_t q_exp[$];
  int   q_acc[$];
  int   n_acc    = 0;
  bit   hs_mode  = 0;
  bit   have_last = 0;
  int   last_acc = 0;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (q_acc.size() > 0) begin
        if (cyc - q_acc[0] >= 1 && cyc - q_acc[0] <= 4) begin
          chk("ready_busy", 32'(bus.req_ready), 32'd0);
          chk("ram_en_busy", 32'(bus.ram_en), 32'd1);
        end
      end
      if (bus.ram_write_en) begin
        if (q_exp.size() == 0 || q_acc.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(bus.ram_wr_addr), 32'(q_exp[0].addr));
          chk("wr_data", 32'(bus.ram_wr_data), 32'(q_exp[0].word));
          chk("wr_latency", 32'(cyc - q_acc[0]), 32'd3);
        end
      end
      if (bus.done) begin
        if (q_exp.size() == 0 || q_acc.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          chk("best_action", 32'(bus.best_action), 32'(q_exp[0].best));
          chk("done_latency", 32'(cyc - q_acc[0]), 32'd4);
          void'(q_exp.pop_front());
          void'(q_acc.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        q_acc.push_back(cyc);
        n_acc++;
        if (hs_mode && have_last) chk("accept_gap", 32'(cyc - last_acc), 32'd5);
        have_last = 1;
        last_acc  = cyc;
      end
    end
  end

  // Reference Q-learning update on the shadow table (integer arithmetic)
  function automatic void model(input int s, input int a, input int r, input int sn,
                                input int term, output logic [15:0] w, output logic [1:0] best,
                                output bit sat);
    int mx, q, target, delta, nq, f;
    mx = -1; best = 0;
    for (int i = 0; i < 4; i++) begin
      f = int'(m_ram[sn][i*4 +: 4]);
      if (f > mx) begin mx = f; best = 2'(i); end
    end
    if (term != 0) mx = 0;
    q      = int'(m_ram[s][a*4 +: 4]);
    target = r + mx - (mx / 4);
    delta  = target - q;
    nq     = q + (delta >>> 1);
    sat    = (nq < 0) || (nq > 15);
    if (nq < 0) nq = 0;
    if (nq > 15) nq = 15;
    w = m_ram[s];
    w[a*4 +: 4] = 4'(nq);
    m_ram[s] = w;
  endfunction

  task automatic drive(input int s, input int a, input int r, input int sn, input int term);
    bus.req_state      = 6'(s);
    bus.req_action     = 2'(a);
    bus.req_reward     = 4'(r);
    bus.req_next_state = 6'(sn);
    bus.req_terminal   = (term != 0);
  endtask

  task automatic send(input int s, input int a, input int r, input int sn, input int term);
    @(posedge clk); #1;
    drive(s, a, r, sn, term);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic push_model(input int s, input int a, input int r, input int sn, input int term);
    exp_t e; bit sat;
    model(s, a, r, sn, term, e.word, e.best, sat);
    e.addr = 6'(s);
    q_exp.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q_exp.size() != 0; i++) @(negedge clk);
    if (q_exp.size() != 0) begin
      chk("timeout", 32'(q_exp.size()), 32'd0);
      q_exp.delete();
      q_acc.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    int s; int a; int r; int sn; int term;
    logic [15:0] cur; logic [15:0] nxt;
    logic [15:0] exp_word; int best;
  } vec_t;

  vec_t tbl[6];

  initial begin
    exp_t e;
    logic [15:0] saved;
    int base;

    bus.req_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      ram[i]   = 16'($urandom);
      m_ram[i] = ram[i];
    end

    //          s  a   r  sn term  cur      nxt      exp      best
    tbl[0] = '{ 5, 2,  5,  9, 0, 16'h0000, 16'h1234, 16'h0400, 0};
    tbl[1] = '{ 3, 0,  7,  4, 0, 16'h000F, 16'h00F0, 16'h000F, 1};
    tbl[2] = '{ 2, 1, -8,  0, 1, 16'h0020, 16'h0000, 16'h0000, 0};
    tbl[3] = '{ 7, 3,  0,  7, 0, 16'h5555, 16'h5555, 16'h4555, 0};
    tbl[4] = '{10, 1,  3, 11, 1, 16'h0000, 16'h0F00, 16'h0010, 2};
    tbl[5] = '{12, 3, -2, 13, 0, 16'h8000, 16'h0000, 16'h3000, 0};

    // Reset state
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_write_en", 32'(bus.ram_write_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_best", 32'(bus.best_action), 32'd0);
    chk("rst_rd_addr", 32'(bus.ram_rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.ram_wr_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      ram[tbl[i].s]    = tbl[i].cur;  m_ram[tbl[i].s]  = tbl[i].cur;
      ram[tbl[i].sn]   = tbl[i].nxt;  m_ram[tbl[i].sn] = tbl[i].nxt;
      e.addr = 6'(tbl[i].s); e.word = tbl[i].exp_word; e.best = 2'(tbl[i].best);
      q_exp.push_back(e);
      m_ram[tbl[i].s] = tbl[i].exp_word;
      send(tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].sn, tbl[i].term);
      wait_idle();
      chk("ram_after", 32'(ram[tbl[i].s]), 32'(tbl[i].exp_word));
    end
`ifdef Q_UPDATE_STATS_EN
    chk("upd_count", 32'(upd_count), 32'd6);
    chk("sat_count", 32'(sat_count), 32'd2);
`endif
    chk("idle_rd_addr", 32'(bus.ram_rd_addr), 32'd0);

    // Random transitions checked against the reference model
    for (int i = 0; i < 10; i++) begin
      int s, a, r, sn, t;
      s = $urandom_range(0, 63); a = $urandom_range(0, 3);
      r = $urandom_range(0, 15) - 8; sn = $urandom_range(0, 63);
      t = ($urandom_range(0, 3) == 0) ? 1 : 0;
      push_model(s, a, r, sn, t);
      send(s, a, r, sn, t);
      wait_idle();
    end

    // req_valid held high: one acceptance every 5 cycles
    for (int i = 0; i < 3; i++) push_model(20, 1, 2, 21, 0);
    base = n_acc; hs_mode = 1; have_last = 0;
    @(posedge clk); #1;
    drive(20, 1, 2, 21, 0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (n_acc >= base + 3) break;
    end
    bus.req_valid = 1'b0;
    chk("hs_accepts", 32'(n_acc - base), 32'd3);
    wait_idle();
    hs_mode = 0;

    // Reset during RD_CUR: no write, immediate idle
    saved = ram[30];
    @(posedge clk); #1;
    drive(30, 0, 5, 31, 0);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_write_en", 32'(bus.ram_write_en), 32'd0);
    chk("midrst_ram_en", 32'(bus.ram_en), 32'd0);
    q_exp.delete(); q_acc.delete();
    repeat (4) @(posedge clk);
    chk("midrst_ram", 32'(ram[30]), 32'(saved));
    @(negedge clk) rst = 1'b0;
`ifdef Q_UPDATE_STATS_EN
    chk("midrst_upd_count", 32'(upd_count), 32'd0);
`endif
    push_model(30, 0, 5, 31, 0);
    send(30, 0, 5, 31, 0);
    wait_idle();
    chk("post_rst_ram", 32'(ram[30]), 32'(m_ram[30]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
